// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared floating-point format constants and the pre-normaliser state type.
//   FPWID     : total format width
//   MSB       : sign bit index
//   EMSB      : exponent MSB index
//   FMSB      : stored-fraction MSB index (hidden bit sits at FMSB+1)
//   EXPW      : width of the widened signed exponent (two guard bits)
//   LZCW      : width of the shift counter
//   state_t   : pre-normaliser FSM states
// -----------------------------------------------------------------------------
package fp_pkg;

    function automatic int fp_emsb(input int fpwid);
        case (fpwid)
            128:     return 14;
            80:      return 14;
            64:      return 10;
            52:      return 10;
            48:      return 10;
            44:      return 10;
            42:      return 10;
            40:      return 9;
            32:      return 7;
            24:      return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int fp_fmsb(input int fpwid);
        case (fpwid)
            128:     return 111;
            80:      return 63;
            64:      return 51;
            52:      return 39;
            48:      return 35;
            44:      return 31;
            42:      return 29;
            40:      return 28;
            32:      return 22;
            24:      return 15;
            default: return 9;
        endcase
    endfunction

    localparam int FPWID = 32;
    localparam int MSB   = FPWID - 1;
    localparam int EMSB  = fp_emsb(FPWID);
    localparam int FMSB  = fp_fmsb(FPWID);
    // Two extra bits: one so the biased exponent stays positive, one for sign,
    // which keeps the exponent from wrapping over the full FMSB+1 shifts.
    localparam int EXPW  = EMSB + 3;
    localparam int LZCW  = $clog2(FMSB + 2) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_prenorm_seq.sv
// -----------------------------------------------------------------------------
// fp_prenorm_seq
// Iterative pre-normaliser placed after the floating-point decompose stage.
// Denormal significands are shifted left one bit per enabled cycle until the
// hidden-bit position is set, with the widened exponent decremented per shift.
// Format width comes from fp_pkg::FPWID.
//   clk, rst, ce          : clock, synchronous active-high reset, clock enable
//   i_vld / i_rdy         : input handshake
//   i_sgn, i_exp, i_fract : decomposed operand (hidden bit already recovered)
//   i_xz, i_vz, i_xinf,
//   i_nan, i_snan         : class flags from decompose
//   o_vld / o_rdy         : output handshake
//   o_sgn, o_exp, o_fract : normalised result (o_exp signed, biased)
//   o_lzc                 : number of shifts applied
//   o_zero, o_inf,
//   o_nan, o_snan         : result class
// -----------------------------------------------------------------------------
module fp_prenorm_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            i_vld,
    output logic            i_rdy,
    input  logic            i_sgn,
    input  logic [EMSB:0]   i_exp,
    input  logic [FMSB+1:0] i_fract,
    input  logic            i_xz,
    input  logic            i_vz,
    input  logic            i_xinf,
    input  logic            i_nan,
    input  logic            i_snan,
    output logic            o_vld,
    input  logic            o_rdy,
    output logic            o_sgn,
    output logic [EXPW-1:0] o_exp,
    output logic [FMSB+1:0] o_fract,
    output logic [LZCW-1:0] o_lzc,
    output logic            o_zero,
    output logic            o_inf,
    output logic            o_nan,
    output logic            o_snan
);

    state_t            state_q;
    logic              sgn_q;
    logic [EXPW-1:0]   exp_q;
    logic [FMSB+1:0]   fract_q;
    logic [LZCW-1:0]   lzc_q;
    logic              zero_q;
    logic              inf_q;
    logic              nan_q;
    logic              snan_q;

    logic              accept;
    logic              is_denorm;
    logic              shift_done;

    assign i_rdy     = (state_q == IDLE) | ((state_q == DONE) & o_rdy);
    assign o_vld     = (state_q == DONE);
    assign accept    = ce & i_vld & i_rdy;
    assign is_denorm = i_xz & ~i_vz;
    // The counter bound only matters for an all-zero fraction flagged as a
    // denormal; it keeps the FSM from spinning forever on such input.
    assign shift_done = fract_q[FMSB+1] | (lzc_q == LZCW'(FMSB + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            exp_q   <= '0;
            fract_q <= '0;
            lzc_q   <= '0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            snan_q  <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                sgn_q   <= i_sgn;
                zero_q  <= i_vz;
                inf_q   <= i_xinf & ~i_nan;
                nan_q   <= i_nan;
                snan_q  <= i_snan;
                lzc_q   <= '0;
                fract_q <= i_fract;
                if (is_denorm) begin
                    // Denormals carry an effective exponent of 1, not 0.
                    exp_q   <= EXPW'(1);
                    state_q <= SHIFT;
                end else begin
                    exp_q   <= {2'b00, i_exp};
                    state_q <= DONE;
                end
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (shift_done) begin
                            state_q <= DONE;
                        end else begin
                            fract_q <= {fract_q[FMSB:0], 1'b0};
                            exp_q   <= exp_q - EXPW'(1);
                            lzc_q   <= lzc_q + LZCW'(1);
                        end
                    end
                    DONE: begin
                        // A new operand in this state is handled by accept.
                        if (o_rdy) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_sgn   = sgn_q;
    assign o_exp   = exp_q;
    assign o_fract = fract_q;
    assign o_lzc   = lzc_q;
    assign o_zero  = zero_q;
    assign o_inf   = inf_q;
    assign o_nan   = nan_q;
    assign o_snan  = snan_q;

endmodule

// File: tb/tb_fp_prenorm_seq.sv
module tb_fp_prenorm_seq;
    import fp_pkg::*;

    logic            clk = 1'b0;
    logic            rst, ce, i_vld, i_rdy, i_sgn;
    logic [EMSB:0]   i_exp;
    logic [FMSB+1:0] i_fract;
    logic            i_xz, i_vz, i_xinf, i_nan, i_snan;
    logic            o_vld, o_rdy, o_sgn;
    logic [EXPW-1:0] o_exp;
    logic [FMSB+1:0] o_fract;
    logic [LZCW-1:0] o_lzc;
    logic            o_zero, o_inf, o_nan, o_snan;

    always #5 clk = ~clk;

    fp_prenorm_seq dut (
        .clk(clk), .rst(rst), .ce(ce),
        .i_vld(i_vld), .i_rdy(i_rdy), .i_sgn(i_sgn), .i_exp(i_exp), .i_fract(i_fract),
        .i_xz(i_xz), .i_vz(i_vz), .i_xinf(i_xinf), .i_nan(i_nan), .i_snan(i_snan),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_sgn(o_sgn), .o_exp(o_exp), .o_fract(o_fract),
        .o_lzc(o_lzc), .o_zero(o_zero), .o_inf(o_inf), .o_nan(o_nan), .o_snan(o_snan)
    );

    typedef struct packed {
        logic            sgn;
        logic [EXPW-1:0] exp;
        logic [FMSB+1:0] fract;
        logic [LZCW-1:0] lzc;
        logic            zero;
        logic            inf;
        logic            nan;
        logic            snan;
    } res_t;

    typedef struct {
        logic            sgn;
        logic [EMSB:0]   exp;
        logic [FMSB+1:0] fract;
        logic            xz, vz, xinf, nan, snan;
        res_t            want;
        int              lat;
    } vec_t;

    res_t   got;
    assign got = {o_sgn, o_exp, o_fract, o_lzc, o_zero, o_inf, o_nan, o_snan};

    res_t   sbq[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    vec_t   tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard consumer: compare each output transfer with the oldest expectation.
    always @(negedge clk) begin
        res_t w;
        if (!rst && ce && o_vld && o_rdy) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: actual=%h required=none", got);
            end else begin
                w = sbq.pop_front();
                check("sb_result", got, w);
            end
        end
    end

    function automatic res_t mkr(input logic s, input logic [EXPW-1:0] e, input logic [FMSB+1:0] f,
                                 input int lz, input logic z, input logic inf, input logic n, input logic sn);
        res_t r;
        r.sgn = s; r.exp = e; r.fract = f; r.lzc = LZCW'(lz);
        r.zero = z; r.inf = inf; r.nan = n; r.snan = sn;
        return r;
    endfunction

    function automatic vec_t mkv(input logic s, input logic [EMSB:0] e, input logic [FMSB+1:0] f,
                                 input logic xz, input logic vz, input logic xinf, input logic n,
                                 input logic sn, input res_t want, input int lat);
        vec_t v;
        v.sgn = s; v.exp = e; v.fract = f; v.xz = xz; v.vz = vz;
        v.xinf = xinf; v.nan = n; v.snan = sn; v.want = want; v.lat = lat;
        return v;
    endfunction

    // Reference behaviour: count leading zeros directly and apply in one go.
    function automatic res_t model(input logic s, input logic [EMSB:0] e, input logic [FMSB+1:0] f,
                                   input logic xz, input logic vz, input logic xinf,
                                   input logic n, input logic sn);
        res_t r;
        int   lz;
        r = mkr(s, {2'b00, e}, f, 0, vz, xinf & ~n, n, sn);
        if (xz && !vz) begin
            lz = 0;
            for (int i = FMSB + 1; i >= 0 && !f[i]; i--) lz++;
            if (lz > FMSB + 1) lz = FMSB + 1;
            r.fract = f << lz;
            r.exp   = EXPW'(1 - lz);
            r.lzc   = LZCW'(lz);
        end
        return r;
    endfunction

    // Drive one operand, queue its expectation, and return 1 ns after the accepting edge.
    task automatic drive_op(input vec_t v, input bit rnd);
        i_vld = 1'b1; i_sgn = v.sgn; i_exp = v.exp; i_fract = v.fract;
        i_xz = v.xz; i_vz = v.vz; i_xinf = v.xinf; i_nan = v.nan; i_snan = v.snan;
        sbq.push_back(v.want);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (ce && i_rdy) break;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout: actual=no_accept required=accept");
                break;
            end
            @(posedge clk); #1;
            if (rnd) o_rdy = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        i_vld = 1'b0;
        if (rnd) o_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_lat(input string name, input int want);
        int lat;
        lat = 1;
        while (!o_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check(name, 64'(lat), 64'(want));
    endtask

    task automatic drain();
        int n;
        o_rdy = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   c0, kind;
        logic [FMSB:0] r23;
        res_t snap;

        rst = 1'b1; ce = 1'b1; i_vld = 1'b0; o_rdy = 1'b0;
        i_sgn = 1'b0; i_exp = '0; i_fract = '0;
        i_xz = 1'b0; i_vz = 1'b0; i_xinf = 1'b0; i_nan = 1'b0; i_snan = 1'b0;

        tbl[0] = mkv(0, 8'h7F, 24'h800000, 0, 0, 0, 0, 0, mkr(0, 10'd127,  24'h800000, 0,  0, 0, 0, 0), 1);
        tbl[1] = mkv(0, 8'h00, 24'h000001, 1, 0, 0, 0, 0, mkr(0, 10'h3EA,  24'h800000, 23, 0, 0, 0, 0), 25);
        tbl[2] = mkv(0, 8'h00, 24'h000000, 1, 1, 0, 0, 0, mkr(0, 10'h000,  24'h000000, 0,  1, 0, 0, 0), 1);
        tbl[3] = mkv(0, 8'hFF, 24'h800000, 0, 0, 1, 0, 0, mkr(0, 10'h0FF,  24'h800000, 0,  0, 1, 0, 0), 1);
        tbl[4] = mkv(0, 8'hFF, 24'h800001, 0, 0, 1, 1, 1, mkr(0, 10'h0FF,  24'h800001, 0,  0, 0, 1, 1), 1);
        tbl[5] = mkv(1, 8'hFF, 24'hC00000, 0, 0, 1, 1, 0, mkr(1, 10'h0FF,  24'hC00000, 0,  0, 0, 1, 0), 1);
        tbl[6] = mkv(1, 8'h80, 24'hA00000, 0, 0, 0, 0, 0, mkr(1, 10'h080,  24'hA00000, 0,  0, 0, 0, 0), 1);
        tbl[7] = mkv(0, 8'h00, 24'h400000, 1, 0, 0, 0, 0, mkr(0, 10'h000,  24'h800000, 1,  0, 0, 0, 0), 3);
        tbl[8] = mkv(1, 8'h00, 24'h7FFFFF, 1, 0, 0, 0, 0, mkr(1, 10'h000,  24'hFFFFFE, 1,  0, 0, 0, 0), 3);
        tbl[9] = mkv(0, 8'h00, 24'h000F00, 1, 0, 0, 0, 0, mkr(0, 10'h3F5,  24'hF00000, 12, 0, 0, 0, 0), 14);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_vld", 64'(o_vld), 64'd0);
        check("rst_i_rdy", 64'(i_rdy), 64'd1);
        check("rst_outputs", 64'(got), 64'd0);
        rst = 1'b0;

        // Table-driven vectors with latency
        foreach (tbl[k]) begin
            o_rdy = 1'b1;
            drive_op(tbl[k], 1'b0);
            wait_lat($sformatf("lat_vec%0d", k), tbl[k].lat);
            drain();
        end

        // Backpressure: result must hold while the consumer stalls
        o_rdy = 1'b0;
        drive_op(mkv(0, 8'h00, 24'h100000, 1, 0, 0, 0, 0, mkr(0, 10'h3FE, 24'h800000, 3, 0, 0, 0, 0), 5), 1'b0);
        wait_lat("lat_bp", 5);
        snap = got;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold", 64'(got), 64'(mkr(0, 10'h3FE, 24'h800000, 3, 0, 0, 0, 0)));
            check("bp_i_rdy", 64'(i_rdy), 64'd0);
        end
        check("bp_snapshot", 64'(got), 64'(snap));
        drain();

        // Clock enable low in the middle of shifting
        o_rdy = 1'b1;
        drive_op(mkv(0, 8'h00, 24'h100000, 1, 0, 0, 0, 0, mkr(0, 10'h3FE, 24'h800000, 3, 0, 0, 0, 0), 7), 1'b0);
        @(posedge clk); #1;
        ce = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("ce_hold_lzc", 64'(o_lzc), 64'd1);
            check("ce_hold_vld", 64'(o_vld), 64'd0);
        end
        ce = 1'b1;
        wait_lat("ce_lat_rest", 4);
        check("ce_final_lzc", 64'(o_lzc), 64'd3);
        check("ce_final_exp", 64'(o_exp), 64'h3FE);
        drain();

        // Reset while shifting discards the operand
        o_rdy = 1'b0;
        drive_op(tbl[1], 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        check("midrst_o_vld", 64'(o_vld), 64'd0);
        check("midrst_idle", 64'(i_rdy), 64'd1);
        check("midrst_outputs", 64'(got), 64'd0);

        // Back-to-back normals at full throughput
        o_rdy = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            v = mkv(k[0], 8'(8'h7E + k), 24'h800000 | 24'(k * 24'h012345), 0, 0, 0, 0, 0,
                    mkr(0, 0, 0, 0, 0, 0, 0, 0), 1);
            v.want = model(v.sgn, v.exp, v.fract, v.xz, v.vz, v.xinf, v.nan, v.snan);
            drive_op(v, 1'b0);
            check($sformatf("b2b_vld%0d", k), 64'(o_vld), 64'd1);
        end
        check("b2b_cycles", 64'(cyc - c0), 64'd3);
        drain();

        // Random mix with random backpressure
        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 3);
            r23  = (FMSB+1)'($urandom);
            case (kind)
                0: v = mkv(1'($urandom), 8'($urandom_range(1, 254)), {1'b1, r23}, 0, 0, 0, 0, 0,
                           mkr(0, 0, 0, 0, 0, 0, 0, 0), 0);
                1: v = mkv(1'($urandom), 8'h00, {1'b0, (r23 == 0) ? 23'h1 : r23}, 1, 0, 0, 0, 0,
                           mkr(0, 0, 0, 0, 0, 0, 0, 0), 0);
                2: v = mkv(1'($urandom), 8'h00, 24'h0, 1, 1, 0, 0, 0, mkr(0, 0, 0, 0, 0, 0, 0, 0), 0);
                default: v = mkv(1'($urandom), 8'hFF, {1'b1, r23}, 0, 0, 1, (r23 != 0),
                                 (r23 != 0) && !r23[FMSB], mkr(0, 0, 0, 0, 0, 0, 0, 0), 0);
            endcase
            v.want = model(v.sgn, v.exp, v.fract, v.xz, v.vz, v.xinf, v.nan, v.snan);
            drive_op(v, 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
